// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add unsigned multiplier: WIDTH x WIDTH -> 2*WIDTH bits.
// Define SHIFT_ADD_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   mcand_sh;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   step;
  logic [PW-1:0]   sum;
  logic [PW-1:0]   carry;
  logic            finish_c;

  // Ripple-carry adder; the final carry-out cannot be set for legal operands, so it is not built.
  always_comb begin
    sum   = '0;
    carry = '0;
    for (int i = 0; i < int'(PW); i++) begin
      sum[i] = product[i] ^ mcand_sh[i] ^ carry[i];
      if (i < int'(PW) - 1)
        carry[i+1] = (product[i] & mcand_sh[i]) | (carry[i] & (product[i] ^ mcand_sh[i]));
    end
  end

`ifdef SHIFT_ADD_EARLY_TERM_EN
  // Post-shift multiplier is zero once every bit above bit 0 is clear.
  assign finish_c = (step == LAST_STEP) || (mplier[WIDTH-1:1] == '0);
`else
  assign finish_c = (step == LAST_STEP);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      product  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mcand_sh <= '0;
      mplier   <= '0;
      step     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand_sh <= {{WIDTH{1'b0}}, a};
            mplier   <= b;
            product  <= '0;
            step     <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          if (mplier[0])
            product <= sum;
          mcand_sh <= mcand_sh << 1;
          mplier   <= mplier >> 1;
          step     <= step + CW'(1);
          if (finish_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
